// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Bundles the decode claim/read-check signals, the ALU and
//                load write-back handshakes, and the register-file write port
//                driven by regfile_write_arbiter.
//                master : decode / execute / memory side plus register file
//                slave  : the arbiter itself
//  Ports       : claim_*  decode destination claim and its acceptance
//                use*/ra* decode read addresses, stall back to decode
//                alu_*    ALU write-back request/grant
//                mem_*    load write-back request/grant
//                rf_*     register file WE3/RA3/WD3
//                pc_drop  write to the PC register was discarded
//                busy     pending-write scoreboard (debug)
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                   claim_valid;
  logic [ADDR_W-1:0]      claim_addr;
  logic                   claim_ready;
  logic                   use1;
  logic                   use2;
  logic [ADDR_W-1:0]      ra1;
  logic [ADDR_W-1:0]      ra2;
  logic                   stall;
  logic                   alu_valid;
  logic [ADDR_W-1:0]      alu_addr;
  logic [DATA_W-1:0]      alu_data;
  logic                   alu_ready;
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic                   mem_ready;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_wa;
  logic [DATA_W-1:0]      rf_wd;
  logic                   pc_drop;
  logic [(1<<ADDR_W)-1:0] busy;

  modport master (
    output claim_valid, claim_addr, use1, use2, ra1, ra2,
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  claim_ready, stall, alu_ready, mem_ready,
    input  rf_we, rf_wa, rf_wd, pc_drop, busy
  );

  modport slave (
    input  claim_valid, claim_addr, use1, use2, ra1, ra2,
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output claim_ready, stall, alu_ready, mem_ready,
    output rf_we, rf_wa, rf_wd, pc_drop, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin arbiter sharing the register file's single write
//                port between ALU and load write-back, with a per-register
//                pending-write scoreboard used by decode to stall reads.
//  Ports       : clk  posedge clock
//                rst  synchronous active-high reset
//                bus  regfile_write_arbiter_if.slave (claims, read checks,
//                     ALU/load requests, register file write port, debug)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);
  localparam int                c_NREG    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_PC_ADDR = ADDR_W'(PC_REG);

  // State records which requester received the most recent grant.
  typedef enum logic [0:0] {
    S_LAST_ALU = 1'b0,
    S_LAST_MEM = 1'b1
  } last_t;

  last_t              r_last;
  logic               r_rf_we;
  logic [ADDR_W-1:0]  r_rf_wa;
  logic [DATA_W-1:0]  r_rf_wd;
  logic               r_pc_drop;
  logic [c_NREG-1:0]  r_busy;

  logic               w_gnt_alu;
  logic               w_gnt_mem;
  logic               w_gnt_any;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_data;
  logic               w_gnt_pc;
  logic               w_claim_ready;
  logic [c_NREG-1:0]  w_clr_vec;
  logic [c_NREG-1:0]  w_set_vec;

  // A lone request always wins; on a tie the requester that did not win
  // last time goes. Nothing is granted while reset is asserted.
  assign w_gnt_alu  = ~rst & bus.alu_valid & (~bus.mem_valid | (r_last == S_LAST_MEM));
  assign w_gnt_mem  = ~rst & bus.mem_valid & (~bus.alu_valid | (r_last == S_LAST_ALU));
  assign w_gnt_any  = w_gnt_alu | w_gnt_mem;
  assign w_gnt_addr = w_gnt_mem ? bus.mem_addr : bus.alu_addr;
  assign w_gnt_data = w_gnt_mem ? bus.mem_data : bus.alu_data;
  assign w_gnt_pc   = w_gnt_any & (w_gnt_addr == c_PC_ADDR);

  assign w_clr_vec  = w_gnt_any ? (c_NREG'(1) << w_gnt_addr) : '0;

  // A claim on a busy register is accepted only if that register's pending
  // write retires this very cycle (the new claim then re-sets the bit).
  assign w_claim_ready = ~rst & (~r_busy[bus.claim_addr] |
                                 (w_gnt_any & (w_gnt_addr == bus.claim_addr)));

  // The PC register is rewritten by the file every cycle, so it is never
  // tracked as pending.
  assign w_set_vec = (bus.claim_valid & w_claim_ready & (bus.claim_addr != c_PC_ADDR))
                     ? (c_NREG'(1) << bus.claim_addr) : '0;

  assign bus.alu_ready   = w_gnt_alu;
  assign bus.mem_ready   = w_gnt_mem;
  assign bus.claim_ready = w_claim_ready;
  // No forwarding: a register being written this cycle is not yet in the file.
  assign bus.stall       = (bus.use1 & r_busy[bus.ra1]) | (bus.use2 & r_busy[bus.ra2]);
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_wa       = r_rf_wa;
  assign bus.rf_wd       = r_rf_wd;
  assign bus.pc_drop     = r_pc_drop;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= S_LAST_MEM;
      r_rf_we   <= 1'b0;
      r_rf_wa   <= '0;
      r_rf_wd   <= '0;
      r_pc_drop <= 1'b0;
      r_busy    <= '0;
    end else begin
      if (w_gnt_alu) begin
        r_last <= S_LAST_ALU;
      end else if (w_gnt_mem) begin
        r_last <= S_LAST_MEM;
      end

      r_rf_we   <= w_gnt_any & ~w_gnt_pc;
      r_pc_drop <= w_gnt_pc;
      // Address/data hold their last written values when no write goes out.
      if (w_gnt_any & ~w_gnt_pc) begin
        r_rf_wa <= w_gnt_addr;
        r_rf_wd <= w_gnt_data;
      end

      // Set after clear so a same-cycle claim wins over the retiring write.
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4), .PC_REG(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then leave time for outputs to settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.claim_valid = 1'b0;
    bus.claim_addr  = '0;
    bus.use1        = 1'b0;
    bus.use2        = 1'b0;
    bus.ra1         = '0;
    bus.ra2         = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    cyc();
    cyc();

    // ---------------- reset state ----------------
    check("rst_rf_we",   64'(bus.rf_we),   64'd0);
    check("rst_rf_wa",   64'(bus.rf_wa),   64'd0);
    check("rst_rf_wd",   64'(bus.rf_wd),   64'd0);
    check("rst_pc_drop", 64'(bus.pc_drop), 64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 32'hA1;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd2; bus.mem_data = 32'hB2;
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd4;
    #1;
    check("rst_alu_ready",   64'(bus.alu_ready),   64'd0);
    check("rst_mem_ready",   64'(bus.mem_ready),   64'd0);
    check("rst_claim_ready", 64'(bus.claim_ready), 64'd0);
    cyc();
    bus.claim_valid = 1'b0;
    rst = 1'b0;
    #1;

    // ---------------- tie after reset: ALU, MEM, ALU, MEM ----------------
    for (int i = 0; i < 4; i++) begin
      check("tie_alu_ready", 64'(bus.alu_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("tie_mem_ready", 64'(bus.mem_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      cyc();
      check("tie_rf_we", 64'(bus.rf_we), 64'd1);
      check("tie_rf_wa", 64'(bus.rf_wa), (i % 2 == 0) ? 64'd1 : 64'd2);
      check("tie_rf_wd", 64'(bus.rf_wd), (i % 2 == 0) ? 64'hA1 : 64'hB2);
    end
    check("tie_busy_clear", 64'(bus.busy), 64'd0);
    idle();
    #1;

    // ---------------- single ALU write ----------------
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'hDEADBEEF;
    #1;
    check("single_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("single_mem_ready", 64'(bus.mem_ready), 64'd0);
    cyc();
    idle();
    check("single_rf_we", 64'(bus.rf_we), 64'd1);
    check("single_rf_wa", 64'(bus.rf_wa), 64'd3);
    check("single_rf_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
    cyc();
    check("idle_rf_we",   64'(bus.rf_we), 64'd0);
    check("idle_rf_wa",   64'(bus.rf_wa), 64'd3);
    check("idle_rf_wd",   64'(bus.rf_wd), 64'hDEADBEEF);

    // ---------------- scoreboard stall on r5 ----------------
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd5;
    #1;
    check("sb_claim_ready", 64'(bus.claim_ready), 64'd1);
    cyc();
    bus.claim_valid = 1'b0;
    bus.use1 = 1'b1; bus.ra1 = 4'd5;
    bus.use2 = 1'b1; bus.ra2 = 4'd6;
    #1;
    check("sb_busy_set", 64'(bus.busy), 64'h20);
    check("sb_stall_1",  64'(bus.stall), 64'd1);
    cyc();
    check("sb_stall_2",  64'(bus.stall), 64'd1);
    bus.use1 = 1'b0;
    #1;
    check("sb_stall_unused", 64'(bus.stall), 64'd0);
    bus.use1 = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 32'h55;
    #1;
    check("sb_grant_ready", 64'(bus.alu_ready), 64'd1);
    check("sb_grant_stall", 64'(bus.stall), 64'd1);
    cyc();
    bus.alu_valid = 1'b0;
    #1;
    check("sb_after_stall", 64'(bus.stall), 64'd0);
    check("sb_after_busy",  64'(bus.busy), 64'd0);
    check("sb_after_wa",    64'(bus.rf_wa), 64'd5);
    idle();

    // ---------------- WAW on r2 ----------------
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd2;
    #1;
    check("waw_first_ready", 64'(bus.claim_ready), 64'd1);
    cyc();
    #1;
    check("waw_second_ready", 64'(bus.claim_ready), 64'd0);
    cyc();
    check("waw_hold_busy",  64'(bus.busy), 64'h4);
    check("waw_hold_ready", 64'(bus.claim_ready), 64'd0);
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd2; bus.mem_data = 32'h22;
    #1;
    check("waw_grant_mem_ready",   64'(bus.mem_ready), 64'd1);
    check("waw_grant_claim_ready", 64'(bus.claim_ready), 64'd1);
    cyc();
    bus.claim_valid = 1'b0;
    check("waw_busy_stays", 64'(bus.busy), 64'h4);
    check("waw_rf_wd",      64'(bus.rf_wd), 64'h22);
    bus.mem_data = 32'h23;
    cyc();
    bus.mem_valid = 1'b0;
    check("waw_busy_clear", 64'(bus.busy), 64'd0);
    check("waw_rf_wd2",     64'(bus.rf_wd), 64'h23);
    idle();

    // ---------------- PC drop ----------------
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd15; bus.mem_data = 32'hF;
    #1;
    check("pc_mem_ready", 64'(bus.mem_ready), 64'd1);
    cyc();
    idle();
    check("pc_rf_we",   64'(bus.rf_we),   64'd0);
    check("pc_drop",    64'(bus.pc_drop), 64'd1);
    check("pc_rf_wa",   64'(bus.rf_wa),   64'd2);
    check("pc_rf_wd",   64'(bus.rf_wd),   64'h23);
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd15;
    #1;
    check("pc_claim_ready", 64'(bus.claim_ready), 64'd1);
    cyc();
    bus.claim_valid = 1'b0;
    check("pc_drop_pulse", 64'(bus.pc_drop), 64'd0);
    check("pc_claim_busy", 64'(bus.busy), 64'd0);

    // ---------------- reset mid-stream ----------------
    // Last grant was MEM (PC write), so ALU wins this tie.
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 32'h77;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd8; bus.mem_data = 32'h88;
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd9;
    #1;
    check("mid_alu_ready", 64'(bus.alu_ready), 64'd1);
    cyc();
    bus.claim_valid = 1'b0;
    check("mid_rf_we",  64'(bus.rf_we), 64'd1);
    check("mid_busy",   64'(bus.busy),  64'h200);
    rst = 1'b1;
    #1;
    check("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    check("mid_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    cyc();
    check("mid_rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("mid_rst_rf_wa", 64'(bus.rf_wa), 64'd0);
    check("mid_rst_rf_wd", 64'(bus.rf_wd), 64'd0);
    check("mid_rst_busy",  64'(bus.busy),  64'd0);
    rst = 1'b0;
    #1;
    // Without the reset, MEM would have won this tie.
    check("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("post_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    cyc();
    check("post_rst_rf_wa", 64'(bus.rf_wa), 64'd7);
    #1;
    check("post_rst_mem_turn", 64'(bus.mem_ready), 64'd1);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
